pipe_stage_buffer: RTL
======================

// Module: pipe_stage_buffer
// PURPOSE
//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.
//  Replaces per-bit dff chains with one generic stage.
//  Adds per-stage valid, back-pressure, synchronous flush (bubble insertion) and an optional skid entry.
//  With the skid entry fitted, in_ready is a registered signal, so stall paths do not chain combinationally.
// PARAMETERS
//  DATA_W   16  width of datapath payload (operands, imm, next PC); concatenate as needed
//  CTRL_W   12  width of control payload (reg_write, mem_read, hlt, ...); zeroed on flush/reset
//  SKID     1   1 = two-entry skid buffer, registered in_ready; 0 = single entry, combinational in_ready
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  flush      in   1       synchronous squash of every held and incoming entry
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage accepts an entry this cycle
//  in_ctrl    in   CTRL_W  upstream control bits
//  in_data    in   DATA_W  upstream data bits
//  out_valid  out  1       output entry valid
//  out_ready  in   1       downstream accepts the output entry
//  out_ctrl   out  CTRL_W  output control bits; all zero whenever out_valid=0
//  out_data   out  DATA_W  output data bits; don't-care when out_valid=0, but held stable
// BEHAVIOUR
//  - Transfers: accept when in_valid&in_ready; emit when out_valid&out_ready.
//  - Reset (rst=0, async): out_valid=0, out_ctrl=0, out_data=0, skid empty.
//    SKID=1: in_ready=1. SKID=0: in_ready=1 via ~out_valid.
//    After rst deasserts, the first accept is possible on the first rising edge.
//  - Latency: 1 cycle in->out when the stage is empty or draining.
//    A byte accepted at edge N is visible on out_* after edge N.
//  - Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
//  - out_* hold stable while out_valid=1 and out_ready=0.
//  - SKID=0, single entry:
//    - in_ready = out_ready | ~out_valid (combinational).
//    - Accept with simultaneous emit replaces the main entry.
//  - SKID=1, states (main,skid):
//    - EMPTY(0,0): accept -> FULL.
//    - FULL(1,0):
//      - emit & no accept -> EMPTY.
//      - accept & emit -> FULL, main loaded with the new entry.
//      - accept & no emit -> SKID; the new entry goes to the skid register.
//    - SKID(1,1): in_ready=0. emit -> FULL; the skid entry moves to main the same edge.
//    - in_ready = ~skid_valid, driven from a flop.
//  - Flush (synchronous, priority over all transfers):
//    - At the edge: main_valid=0, skid_valid=0, out_ctrl=0, in_ready next=1.
//    - An entry offered in the flush cycle is discarded.
//    - out_data keeps its last value.
//    - Flush while rst=0 has no effect.
//  - Bubble guarantee: out_ctrl=0 whenever out_valid=0, so downstream sees a NOP without decoding out_valid.
//  - Widths: payload is copied verbatim; no arithmetic.
//    DATA_W>=1 and CTRL_W>=1 are required; other values are illegal at elaboration.
//  - Reset mid-operation: all held entries are lost immediately, asynchronously; there is no partial output.
// TESTING
//  - Reset: drive rst=0 mid-stream holding 2 entries.
//    -> out_valid=0, out_ctrl=0, out_data=0 same cycle; SKID=1 in_ready=1 next edge.
//  - Streaming: out_ready=1, push data 0x0001..0x0010 on consecutive cycles.
//    -> identical sequence out, 1-cycle latency, in_ready stays 1.
//  - Stall (SKID=1): push 0xA1,0xA2,0xA3 with out_ready=0.
//    -> 0xA1 held on out, 0xA2 in skid, in_ready=0, 0xA3 held upstream.
//    Release -> 0xA1,0xA2,0xA3 out in order.
//  - Flush: stage holding 0xB1 (ctrl=0xFFF) and skid 0xB2; assert flush with in_valid=1 data 0xB3.
//    -> next cycle out_valid=0, out_ctrl=0, 0xB3 never appears.
//  - Simultaneous accept+emit in FULL with SKID=0 and SKID=1: 0xC1 out, 0xC2 in.
//    -> 0xC2 on out next cycle, no bubble, no duplicate.
//  - Random valid/ready/flush for 10k cycles, compared against a reference queue model.
//    -> no loss, duplication or reorder; out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: valid/ready inter-stage register with flush and optional skid entry
module pipe_stage_buffer #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 12,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);
    if (DATA_W < 1 || CTRL_W < 1) begin : g_bad_width
        $error("pipe_stage_buffer: DATA_W and CTRL_W must be at least 1");
    end

    // Encoding makes out_valid and ~in_ready plain state bits, so both come straight off flops.
    typedef enum logic [1:0] {EMPTY = 2'b00, FULL = 2'b01, HELD = 2'b11} state_t;

    state_t            state, state_nx;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              acc, emit, load_main, load_skid, move_skid;

    assign out_valid = state[0];
    assign in_ready  = SKID ? ~state[1] : (out_ready | ~state[0]);
    assign acc       = in_valid & in_ready & ~flush;
    assign emit      = out_valid & out_ready;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    // State register; reset and flush both leave the stage empty and ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nx;
    end

    // Next state and register load strobes; without a skid entry HELD is unreachable
    // because in_ready already drops whenever the held entry cannot leave.
    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                state_nx  = acc ? FULL : EMPTY;
                load_main = acc;
            end
            FULL: begin
                state_nx  = (acc && !emit) ? HELD : ((emit && !acc) ? EMPTY : FULL);
                load_main = acc && emit;
                load_skid = acc && !emit;
            end
            default: begin
                state_nx  = out_ready ? FULL : HELD;
                move_skid = out_ready && !flush;
            end
        endcase
        if (flush) state_nx = EMPTY;
    end

    // Payload registers; flush never touches them, so out_data holds its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (load_main) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (move_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end
endmodule
